// File: rtl/audio_mix_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : audio_mix_sequencer_pkg                                       |
// | Purpose  : Shared constants, FSM state encoding and volume address       |
// |            layout for the time-multiplexed stereo mixer.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package audio_mix_sequencer_pkg;

  localparam int DW        = 16;
  localparam int VW        = 8;
  localparam int VOL_SHIFT = 7;
  localparam int NCH_DEF   = 8;
  localparam int VOL_UNITY = 128;

  // vol_addr = {channel[3:0], side}
  localparam int   VA_W        = 5;
  localparam int   VA_SIDE_BIT = 0;
  localparam int   VA_CH_LSB   = 1;
  localparam int   VA_CH_W     = 4;
  localparam logic VA_SIDE_L   = 1'b0;
  localparam logic VA_SIDE_R   = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC_L = 3'd2,
    MAC_R = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/audio_mix_sequencer_sat_shift.sv
// +--------------------------------------------------------------------------+
// | Module   : audio_sat_shift                                               |
// | Purpose  : Arithmetic right shift (floor) followed by saturation from an  |
// |            IW-bit signed accumulator to an OW-bit signed sample.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module audio_sat_shift #(
  parameter int IW    = 28,
  parameter int OW    = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout
);

  logic signed [IW-1:0] shifted;
  logic        [IW-OW:0] upper;

  // Shift, then clamp when the bits above the output sign bit disagree
  always_comb begin
    shifted = din >>> SHIFT;
    upper   = shifted[IW-1:OW-1];
    if ((&upper) || (~|upper)) begin
      dout = shifted[OW-1:0];
    end else if (shifted[IW-1]) begin
      dout = {1'b1, {(OW-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OW-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_mix_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module   : audio_mix_sequencer                                           |
// | Purpose  : Per-source volume/pan mixer sharing one multiplier; snapshots |
// |            NCH samples per strobe and emits one saturated stereo pair.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module audio_mix_sequencer #(
  parameter int NCH       = audio_mix_sequencer_pkg::NCH_DEF,
  parameter int DW        = audio_mix_sequencer_pkg::DW,
  parameter int VW        = audio_mix_sequencer_pkg::VW,
  parameter int VOL_SHIFT = audio_mix_sequencer_pkg::VOL_SHIFT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_stb,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              vol_we,
  input  logic [4:0]        vol_addr,
  input  logic [VW-1:0]     vol_data,
  input  logic              mute,
  output logic [DW-1:0]     audio_l,
  output logic [DW-1:0]     audio_r,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  import audio_mix_sequencer_pkg::*;

  localparam int IDXW = $clog2(NCH);
  localparam int PW   = DW + VW + 1;
  localparam int ACCW = PW + $clog2(NCH);

  logic signed [DW-1:0]   ch_in [NCH];
  logic signed [DW-1:0]   snap  [NCH];
  logic        [VW-1:0]   vol_l [NCH];
  logic        [VW-1:0]   vol_r [NCH];
  logic        [VW-1:0]   vol_l_nxt [NCH];
  logic        [VW-1:0]   vol_r_nxt [NCH];
  logic        [VW-1:0]   shd_l [NCH];
  logic        [VW-1:0]   shd_r [NCH];

  state_t                 state;
  logic        [IDXW-1:0] idx;
  logic signed [ACCW-1:0] acc_l;
  logic signed [ACCW-1:0] acc_r;

  logic [VA_CH_W-1:0]     wr_ch;
  logic                   wr_ok;
  logic signed [DW-1:0]   snap_cur;
  logic        [VW-1:0]   vol_cur;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [DW-1:0]   sat_l;
  logic signed [DW-1:0]   sat_r;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign ch_in[gi] = ch_data[gi*DW +: DW];
  end

  assign wr_ch = vol_addr[VA_CH_LSB +: VA_CH_W];
  assign wr_ok = vol_we && (32'(wr_ch) < NCH);

  // Next value of the live volume bank; also feeds the shadow copy so a
  // write landing in LOAD is seen by the frame being started
  always_comb begin
    vol_l_nxt = vol_l;
    vol_r_nxt = vol_r;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ok && (wr_ch == VA_CH_W'(i))) begin
        if (vol_addr[VA_SIDE_BIT] == VA_SIDE_R) vol_r_nxt[i] = vol_data;
        else                                    vol_l_nxt[i] = vol_data;
      end
    end
  end

  // Live volume registers, writable in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        vol_l[i] <= VW'(VOL_UNITY);
        vol_r[i] <= VW'(VOL_UNITY);
      end
    end else begin
      vol_l <= vol_l_nxt;
      vol_r <= vol_r_nxt;
    end
  end

  // Shared multiplier: volume is zero-extended so 255 stays positive
  assign snap_cur = snap[idx];
  assign vol_cur  = (state == MAC_R) ? shd_r[idx] : shd_l[idx];
  assign prod     = $signed({{(VW+1){snap_cur[DW-1]}}, snap_cur})
                  * $signed({{DW{1'b0}}, 1'b0, vol_cur});
  assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

  audio_sat_shift #(.IW(ACCW), .OW(DW), .SHIFT(VOL_SHIFT)) u_sat_l (
    .din  (acc_l),
    .dout (sat_l)
  );

  audio_sat_shift #(.IW(ACCW), .OW(DW), .SHIFT(VOL_SHIFT)) u_sat_r (
    .din  (acc_r),
    .dout (sat_r)
  );

  // Frame sequencer: snapshot, alternating L/R MACs per channel, output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      audio_l   <= '0;
      audio_r   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        snap[i]  <= '0;
        shd_l[i] <= VW'(VOL_UNITY);
        shd_r[i] <= VW'(VOL_UNITY);
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_stb && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_stb) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          snap  <= ch_in;
          shd_l <= vol_l_nxt;
          shd_r <= vol_r_nxt;
          acc_l <= '0;
          acc_r <= '0;
          idx   <= '0;
          state <= MAC_L;
        end
        MAC_L: begin
          acc_l <= acc_l + prod_ext;
          state <= MAC_R;
        end
        MAC_R: begin
          acc_r <= acc_r + prod_ext;
          if (idx == IDXW'(NCH-1)) begin
            state <= OUT;
          end else begin
            idx   <= idx + 1'b1;
            state <= MAC_L;
          end
        end
        OUT: begin
          audio_l   <= mute ? '0 : sat_l;
          audio_r   <= mute ? '0 : sat_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
